// File: rtl/bgr_ctrl_pkg.sv
// Shared types for the bandgap start-up sequencer: FSM state encoding and
// the retry counter width.
package bgr_ctrl_pkg;

  localparam int unsigned RETRY_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    READY  = 3'd4,
    RETRY  = 3'd5,
    FAULT  = 3'd6
  } bgr_state_t;

endpackage

// File: rtl/bgr_sync2.sv
// Two-flop synchronizer for the asynchronous vbg window comparator flag.
module bgr_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: kicks porst, waits for settling, qualifies the
// synchronized vbg_ok flag, re-kicks a bounded number of times, then faults.
module bgr_startup_ctrl
  import bgr_ctrl_pkg::*;
#(
  parameter int unsigned KICK_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned OK_CYCLES     = 8,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               vbg_ok,
  output logic               porst,
  output logic               bgr_ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_o
);

  localparam logic [CNT_W-1:0]   KICK_LD   = CNT_W'(KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OK_MAX    = CNT_W'(OK_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  bgr_state_t         state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   okc_q, okc_d, okc_inc;
  logic [RETRY_W-1:0] retry_d;
  logic               ok_s;

  bgr_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vbg_ok),
    .q     (ok_s)
  );

  assign okc_inc = (okc_q == OK_MAX) ? okc_q : okc_q + 1'b1;
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    okc_d   = okc_q;
    retry_d = retry_cnt;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = KICK;
          timer_d = KICK_LD;
          okc_d   = '0;
          retry_d = '0;
        end
      end
      KICK: begin
        if (timer_q == '0) begin
          state_d = SETTLE;
          timer_d = SETTLE_LD;
        end
      end
      SETTLE: begin
        // The timer is reused as the CHECK qualification window.
        if (timer_q == '0) begin
          state_d = CHECK;
          timer_d = SETTLE_LD;
          okc_d   = '0;
        end
      end
      CHECK: begin
        okc_d = ok_s ? okc_inc : '0;
        if (ok_s && okc_inc == OK_MAX) begin
          state_d = READY;
          okc_d   = '0;
        end else if (timer_q == '0) begin
          state_d = RETRY;
        end
      end
      READY: begin
        okc_d = !ok_s ? okc_inc : '0;
        if (!ok_s && okc_inc == OK_MAX) begin
          state_d = RETRY;
          okc_d   = '0;
        end
      end
      RETRY: begin
        if (retry_cnt == RETRY_MAX) begin
          state_d = FAULT;
        end else begin
          state_d = KICK;
          timer_d = KICK_LD;
          retry_d = retry_cnt + 1'b1;
        end
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      timer_d = '0;
      okc_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      okc_q     <= '0;
      retry_cnt <= '0;
      porst     <= 1'b0;
      bgr_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      okc_q     <= okc_d;
      retry_cnt <= retry_d;
      porst     <= (state_d == KICK);
      bgr_ready <= (state_d == READY);
      fault     <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Self-checking bench for bgr_startup_ctrl: timed expectation tables feed a
// scoreboard checked on the falling edge, plus hand-written reset sequences.
module tb_bgr_startup_ctrl;
  import bgr_ctrl_pkg::*;

  localparam int K = 16;
  localparam int S = 1024;
  localparam int O = 8;
  localparam int P = K + 2 * S + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       vbg_ok = 1'b0;
  logic       porst, bgr_ready, fault;
  logic [2:0] retry_cnt, state_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         t;
    bit         en;
    bit         ok;
    bit         porst;
    bit         ready;
    bit         fault;
    logic [2:0] retry;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    int         cyc;
    int         tag;
    logic [8:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  bgr_startup_ctrl #(
    .KICK_CYCLES   (K),
    .SETTLE_CYCLES (S),
    .OK_CYCLES     (O),
    .MAX_RETRY     (3),
    .CNT_W         (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .vbg_ok    (vbg_ok),
    .porst     (porst),
    .bgr_ready (bgr_ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t row(int t, bit e, bit k, bit p, bit r, bit f, int rc, bgr_state_t st);
    vec_t v;
    v.t = t; v.en = e; v.ok = k;
    v.porst = p; v.ready = r; v.fault = f;
    v.retry = 3'(rc); v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : scoreboard
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc)
        chk($sformatf("late_vec%0d", e.tag), 32'(cyc), 32'(e.cyc));
      else
        chk($sformatf("vec%0d", e.tag),
            32'({porst, bgr_ready, fault, retry_cnt, state_o}), 32'(e.exp));
    end
  end

  // Call just after a falling edge; row t is checked, then driven, at falling edge base+t.
  task automatic run_tbl(input int tagbase);
    int   base;
    exp_t e;
    base = cyc + 1;
    foreach (tbl[i]) begin
      e.cyc = base + tbl[i].t;
      e.tag = tagbase + i;
      e.exp = {tbl[i].porst, tbl[i].ready, tbl[i].fault, tbl[i].retry, tbl[i].st};
      sb.push_back(e);
    end
    foreach (tbl[i]) begin
      do @(negedge clk); while (cyc < base + tbl[i].t);
      #1;
      en     = tbl[i].en;
      vbg_ok = tbl[i].ok;
    end
    tbl.delete();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_porst"}, 32'(porst), 0);
    chk({pfx, "_ready"}, 32'(bgr_ready), 0);
    chk({pfx, "_fault"}, 32'(fault), 0);
    chk({pfx, "_retry"}, 32'(retry_cnt), 0);
    chk({pfx, "_state"}, 32'(state_o), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    int g1, g2, e, f;
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Nominal start-up, short and long READY glitches, then disable.
    g1 = K + S + O + 11;
    g2 = g1 + 30;
    tbl.push_back(row(0,         1, 1, 0, 0, 0, 0, IDLE));
    tbl.push_back(row(1,         1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(K,         1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(K + 1,     1, 1, 0, 0, 0, 0, SETTLE));
    tbl.push_back(row(K + S,     1, 1, 0, 0, 0, 0, SETTLE));
    tbl.push_back(row(K + S + 1, 1, 1, 0, 0, 0, 0, CHECK));
    tbl.push_back(row(K + S + O, 1, 1, 0, 0, 0, 0, CHECK));
    tbl.push_back(row(K + S + O + 1, 1, 1, 0, 1, 0, 0, READY));
    tbl.push_back(row(g1,        1, 0, 0, 1, 0, 0, READY));
    tbl.push_back(row(g1 + 5,    1, 1, 0, 1, 0, 0, READY));
    tbl.push_back(row(g1 + 20,   1, 1, 0, 1, 0, 0, READY));
    tbl.push_back(row(g2,        1, 0, 0, 1, 0, 0, READY));
    tbl.push_back(row(g2 + 9,    1, 0, 0, 1, 0, 0, READY));
    tbl.push_back(row(g2 + 10,   1, 1, 0, 0, 0, 0, RETRY));
    tbl.push_back(row(g2 + 11,   1, 1, 1, 0, 0, 1, KICK));
    tbl.push_back(row(g2 + 10 + K, 1, 1, 1, 0, 0, 1, KICK));
    tbl.push_back(row(g2 + 11 + K, 1, 1, 0, 0, 0, 1, SETTLE));
    tbl.push_back(row(g2 + 11 + K + S + O, 0, 1, 0, 1, 0, 1, READY));
    tbl.push_back(row(g2 + 12 + K + S + O, 0, 1, 0, 0, 0, 0, IDLE));
    run_tbl(100);

    // Disable on the fifth KICK cycle, then re-enable for a full pulse.
    tbl.push_back(row(0,      1, 1, 0, 0, 0, 0, IDLE));
    tbl.push_back(row(1,      1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(5,      0, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(6,      1, 1, 0, 0, 0, 0, IDLE));
    tbl.push_back(row(7,      1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(6 + K,  1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(7 + K,  1, 1, 0, 0, 0, 0, SETTLE));
    run_tbl(200);

    // Asynchronous reset in SETTLE, off the clock edge.
    repeat (40) @(negedge clk);
    chk("settle_before_rst", 32'(state_o), 32'(SETTLE));
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_settle");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tbl.push_back(row(0,             1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(K - 1,         1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(K,             1, 1, 0, 0, 0, 0, SETTLE));
    tbl.push_back(row(K + S + O - 1, 1, 1, 0, 0, 0, 0, CHECK));
    tbl.push_back(row(K + S + O,     0, 1, 0, 1, 0, 0, READY));
    tbl.push_back(row(K + S + O + 1, 0, 1, 0, 0, 0, 0, IDLE));
    run_tbl(300);

    // Asynchronous reset during a kick must drop porst immediately.
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("kick_before_rst", 32'(porst), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_kick");
    repeat (2) @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Never OK: four kicks, retry_cnt 0..3, then FAULT and recovery.
    tbl.push_back(row(0, 1, 0, 0, 0, 0, 0, IDLE));
    for (int unsigned n = 0; n < 4; n++) begin
      e = 1 + int'(n) * P;
      tbl.push_back(row(e,             1, 0, 1, 0, 0, int'(n), KICK));
      tbl.push_back(row(e + K - 1,     1, 0, 1, 0, 0, int'(n), KICK));
      tbl.push_back(row(e + K,         1, 0, 0, 0, 0, int'(n), SETTLE));
      tbl.push_back(row(e + K + S,     1, 0, 0, 0, 0, int'(n), CHECK));
      tbl.push_back(row(e + K + 2 * S, 1, 0, 0, 0, 0, int'(n), RETRY));
    end
    f = 1 + 4 * P;
    tbl.push_back(row(f,      1, 0, 0, 0, 1, 3, FAULT));
    tbl.push_back(row(f + 50, 0, 0, 0, 0, 1, 3, FAULT));
    tbl.push_back(row(f + 51, 1, 1, 0, 0, 0, 0, IDLE));
    tbl.push_back(row(f + 52, 1, 1, 1, 0, 0, 0, KICK));
    tbl.push_back(row(f + 52 + K + S + O - 1, 1, 1, 0, 0, 0, 0, CHECK));
    tbl.push_back(row(f + 52 + K + S + O,     0, 1, 0, 1, 0, 0, READY));
    tbl.push_back(row(f + 53 + K + S + O,     0, 1, 0, 0, 0, 0, IDLE));
    run_tbl(400);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
